// File: rtl/sram_1rw_port_master.sv
// sram_1rw_port_master: valid/ready initiator for port 0 of an OpenRAM 1RW macro.
// Requests are registered onto the macro pins. Read data is captured two cycles
// after accept and returned in order through a credit-gated response FIFO.
module sram_1rw_port_master #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned NUM_WMASKS = 4,
    parameter int unsigned RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic                  idle
);

    localparam int unsigned CNT_W  = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CRED_W = CNT_W + 1;

    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  rd_flag1;
    logic                  rd_flag2;
    logic [CNT_W-1:0]      fifo_count;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CRED_W-1:0]     credits_used;
    logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];

    // Pointer advance with wrap at RSP_DEPTH (depth need not be a power of two).
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(RSP_DEPTH - 1)) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

    // Every read in flight or buffered holds one FIFO slot, so the FIFO can never overflow.
    assign credits_used = CRED_W'(fifo_count) + CRED_W'(rd_flag1) + CRED_W'(rd_flag2);
    assign req_ready    = (credits_used < CRED_W'(RSP_DEPTH));
    assign accept       = req_valid && req_ready;
    assign push         = rd_flag2;
    assign pop          = rsp_valid && rsp_ready;
    assign rsp_valid    = (fifo_count != '0);
    assign rsp_rdata    = fifo_mem[rd_ptr];
    assign idle         = !rd_flag1 && !rd_flag2 && (fifo_count == '0);

    // Register the accepted request onto the macro pins; deselect when nothing is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
            sram_wmask0 <= '0;
            sram_addr0  <= '0;
            sram_din0   <= '0;
        end else if (accept) begin
            sram_csb0   <= 1'b0;
            sram_web0   <= !req_we;
            sram_wmask0 <= req_we ? req_wmask : '0;
            sram_addr0  <= req_addr;
            if (req_we) begin
                sram_din0 <= req_wdata;
            end
        end else begin
            sram_csb0   <= 1'b1;
            sram_web0   <= 1'b1;
            sram_wmask0 <= '0;
        end
    end

    // Read flags: stage 1 = pins driven, stage 2 = macro sampled, dout valid at next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_flag1 <= 1'b0;
            rd_flag2 <= 1'b0;
        end else begin
            rd_flag1 <= accept && !req_we;
            rd_flag2 <= rd_flag1;
        end
    end

    // FIFO pointers and occupancy; push and pop may coincide at any fill level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Capture macro read data into the FIFO storage (data path, no reset needed).
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= sram_dout0;
        end
    end

endmodule

// File: tb/tb_sram_1rw_port_master.sv
// Directed and random bench for sram_1rw_port_master with a behavioural OpenRAM macro model.
module tb_sram_1rw_port_master;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_wmask;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        sram_csb0;
    logic        sram_web0;
    logic [3:0]  sram_wmask0;
    logic [7:0]  sram_addr0;
    logic [31:0] sram_din0;
    logic [31:0] sram_dout0;
    logic        idle;

    int n_checks = 0;
    int n_fail   = 0;

    sram_1rw_port_master #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_WMASKS(4), .RSP_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_wmask(req_wmask), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
        .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro model: pins sampled on rise, write or read performed on the following fall.
    logic [31:0] mem_model [256];
    logic        m_csb = 1'b1;
    logic        m_web = 1'b1;
    logic [3:0]  m_wmask;
    logic [7:0]  m_addr;
    logic [31:0] m_din;

    always @(posedge clk) begin
        m_csb   <= sram_csb0;
        m_web   <= sram_web0;
        m_wmask <= sram_wmask0;
        m_addr  <= sram_addr0;
        m_din   <= sram_din0;
    end

    always @(negedge clk) begin
        if (!m_csb) begin
            if (!m_web) begin
                for (int b = 0; b < 4; b++)
                    if (m_wmask[b]) mem_model[m_addr][b*8 +: 8] <= m_din[b*8 +: 8];
            end else begin
                sram_dout0 <= mem_model[m_addr];
            end
        end
    end

    logic [31:0] ref_mem [256];
    logic [31:0] exp_q [$];

    task automatic set_req(input logic we, input logic [3:0] mask, input logic [7:0] addr,
                           input logic [31:0] data);
        req_valid = 1'b1;
        req_we    = we;
        req_wmask = mask;
        req_addr  = addr;
        req_wdata = data;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_wmask = '0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0} !== {1'b1, 1'b1, 4'h0, 8'h00, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_pins: got csb=%b web=%b wm=%h a=%h d=%h want 1 1 0 00 00000000",
                     sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0);
        end
        n_checks++;
        if ({rsp_valid, idle} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_status: got rsp_valid=%b idle=%b want 0 1", rsp_valid, idle);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({sram_csb0, sram_web0, sram_wmask0, req_ready, rsp_valid, idle} !== {1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL post_reset: got csb=%b web=%b wm=%h rdy=%b rv=%b idle=%b want 1 1 0 1 0 1",
                     sram_csb0, sram_web0, sram_wmask0, req_ready, rsp_valid, idle);
        end
    endtask

    task automatic test_write_read();
        set_req(1'b1, 4'hF, 8'h10, 32'hA5A5_5A5A);
        @(negedge clk);
        n_checks++;
        if ({sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0} !== {1'b0, 1'b0, 4'hF, 8'h10, 32'hA5A5_5A5A}) begin
            n_fail++;
            $display("FAIL write_drive: got csb=%b web=%b wm=%h a=%h d=%h want 0 0 f 10 a5a55a5a",
                     sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0);
        end
        set_req(1'b0, 4'hF, 8'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        n_checks++;
        if ({sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0} !== {1'b0, 1'b1, 4'h0, 8'h10, 32'hA5A5_5A5A}) begin
            n_fail++;
            $display("FAIL read_drive: got csb=%b web=%b wm=%h a=%h d=%h want 0 1 0 10 a5a55a5a",
                     sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0);
        end
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0, rsp_valid} !== {1'b1, 1'b1, 4'h0, 8'h10, 32'hA5A5_5A5A, 1'b0}) begin
            n_fail++;
            $display("FAIL idle_drive: got csb=%b web=%b wm=%h a=%h d=%h rv=%b want 1 1 0 10 a5a55a5a 0",
                     sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0, rsp_valid);
        end
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 32'hA5A5_5A5A}) begin
            n_fail++;
            $display("FAIL raw_read: got rv=%b data=%h want 1 a5a55a5a", rsp_valid, rsp_rdata);
        end
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, idle} !== 2'b01) begin
            n_fail++;
            $display("FAIL raw_drain: got rv=%b idle=%b want 0 1", rsp_valid, idle);
        end
    endtask

    task automatic test_byte_mask();
        set_req(1'b1, 4'hF, 8'h20, 32'h1122_3344);
        @(negedge clk);
        set_req(1'b1, 4'h5, 8'h20, 32'hFFFF_FFFF);
        @(negedge clk);
        set_req(1'b0, 4'h0, 8'h20, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_latency: got rv=%b one cycle after read accept, want 0", rsp_valid);
        end
        @(negedge clk);
        n_checks++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h11FF_33FF}) begin
            n_fail++;
            $display("FAIL mask_read: got rv=%b data=%h want 1 11ff33ff", rsp_valid, rsp_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int got = 0;
        for (int i = 0; i < 6; i++) begin
            set_req(1'b1, 4'hF, 8'(i), 32'h1000 + 32'(i));
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            if (idx < 6) set_req(1'b0, 4'h0, 8'(idx), 32'h0);
            else req_valid = 1'b0;
            if (req_valid && req_ready) idx++;
            @(negedge clk);
        end
        n_checks++;
        if (idx != 4) begin
            n_fail++;
            $display("FAIL bp_accepted: got %0d reads accepted want 4", idx);
        end
        n_checks++;
        if ({req_ready, rsp_valid, rsp_rdata} !== {1'b0, 1'b1, 32'h1000}) begin
            n_fail++;
            $display("FAIL bp_stall: got rdy=%b rv=%b data=%h want 0 1 00001000", req_ready, rsp_valid, rsp_rdata);
        end
        rsp_ready = 1'b1;
        for (int c = 0; c < 40 && got < 6; c++) begin
            if (idx < 6) set_req(1'b0, 4'h0, 8'(idx), 32'h0);
            else req_valid = 1'b0;
            if (req_valid && req_ready) idx++;
            if (rsp_valid && rsp_ready) begin
                n_checks++;
                if (rsp_rdata !== 32'h1000 + 32'(got)) begin
                    n_fail++;
                    $display("FAIL bp_order[%0d]: got %h want %h", got, rsp_rdata, 32'h1000 + 32'(got));
                end
                got++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        n_checks++;
        if (got != 6 || idx != 6) begin
            n_fail++;
            $display("FAIL bp_total: got %0d responses %0d accepts want 6 6", got, idx);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_inflight();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(1'b0, 4'h0, 8'(i), 32'h0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        n_checks++;
        if ({rsp_valid, idle} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_pre: got rv=%b idle=%b want 1 0", rsp_valid, idle);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({sram_csb0, rsp_valid, idle} !== 3'b101) begin
            n_fail++;
            $display("FAIL rst_async: got csb=%b rv=%b idle=%b want 1 0 1", sram_csb0, rsp_valid, idle);
        end
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        begin
            int stale = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (rsp_valid !== 1'b0 || idle !== 1'b1) stale++;
            end
            n_checks++;
            if (stale != 0) begin
                n_fail++;
                $display("FAIL rst_stale: got %0d cycles with response or busy after reset want 0", stale);
            end
        end
    endtask

    task automatic test_random();
        int accepted = 0;
        for (int c = 0; c < 3000 && accepted < 100; c++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_we    = $urandom_range(0, 1) == 1;
            req_wmask = 4'($urandom_range(0, 15));
            req_addr  = 8'h80 + 8'($urandom_range(0, 7));
            req_wdata = $urandom;
            rsp_ready = ($urandom_range(0, 4) < 3);
            if (req_valid && req_ready) begin
                accepted++;
                if (req_we) begin
                    for (int b = 0; b < 4; b++)
                        if (req_wmask[b]) ref_mem[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
                end else begin
                    exp_q.push_back(ref_mem[req_addr]);
                end
            end
            if (rsp_valid && rsp_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra: got unexpected response %h want none", rsp_rdata);
                end else if (rsp_rdata !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL rand_data: got %h want %h", rsp_rdata, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 50 && !(exp_q.size() == 0 && idle); c++) begin
            if (rsp_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra: got unexpected response %h want none", rsp_rdata);
                end else if (rsp_rdata !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL rand_drain: got %h want %h", rsp_rdata, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (accepted != 100 || exp_q.size() != 0 || idle !== 1'b1) begin
            n_fail++;
            $display("FAIL rand_end: got accepted=%0d pending=%0d idle=%b want 100 0 1",
                     accepted, exp_q.size(), idle);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_model[i] = 32'h0;
            ref_mem[i]   = 32'h0;
        end
        sram_dout0 = 32'h0;
        test_reset();
        test_write_read();
        test_byte_mask();
        test_backpressure();
        test_reset_inflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
